waypoint_table: RTL and testbench
=================================

Name: waypoint_table

Overview:
- Parametrised, writable table of DEPTH waypoints; each waypoint holds NDIM coordinates of COORD_W bits.
- Loaded through a write port and replayed in index order through a valid/ready stream to the path/motion consumer.
- Supports one-shot and looping playback, abort, clear, and a live fill count.

Parameters:
- COORD_W, 8, bits per coordinate.
- NDIM, 2, coordinates per waypoint (x = dim 0, y = dim 1, ...).
- DEPTH, 16, number of entries; need not be a power of two, minimum 2.
- IDX_W, $clog2(DEPTH), index width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous active-high reset.
- wr_en  in  1  write strobe.
- wr_idx  in  IDX_W  write index.
- wr_data  in  NDIM*COORD_W  coordinates; dim 0 in the LSBs.
- wr_err  out  1  one-cycle pulse when a write is rejected.
- clear  in  1  empties the table (count to 0).
- start  in  1  begin playback.
- loop_mode  in  1  sampled at start; 1 = wrap to entry 0 after the last entry.
- abort  in  1  stop playback.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_data  out  NDIM*COORD_W  waypoint coordinates.
- out_idx  out  IDX_W  index of out_data.
- busy  out  1  high in STREAM.
- done  out  1  one-cycle pulse at end of one-shot playback.
- count  out  IDX_W+1  number of valid entries.

Behaviour:
- Reset:
  - FSM to IDLE; count, out_valid, out_data, out_idx, busy, done and wr_err all 0.
  - Memory array is not reset; count = 0 makes it unreachable.
- Write (IDLE only):
  - wr_en with wr_idx < DEPTH stores wr_data at the next edge.
  - count <= max(count, wr_idx+1) (high-water mark).
  - Overwriting an existing entry leaves count unchanged.
- Rejected write:
  - Applies when wr_idx >= DEPTH or the FSM is not in IDLE.
  - No store, count unchanged, wr_err = 1 for one cycle.
- clear:
  - Honoured only in IDLE: count <= 0.
  - In STREAM it is ignored.
  - clear with wr_en in the same cycle: clear wins, and the write is dropped without wr_err.
- FSM IDLE -> STREAM:
  - start=1 and count>0.
  - Next edge: out_valid=1, out_idx=0, out_data=entry 0, busy=1; loop_mode latched.
- FSM IDLE with start=1 and count=0:
  - Stay in IDLE; done pulses next cycle; out_valid stays 0.
- FSM STREAM, transfer rule:
  - A transfer occurs on a cycle with out_valid and out_ready both high.
  - out_data and out_idx are held stable while out_valid=1 and out_ready=0.
- STREAM, transfer at idx < count-1: next edge presents idx+1. Back-to-back transfers run at one per cycle.
- STREAM, transfer at idx = count-1:
  - Loop latched: next edge presents idx 0; stay in STREAM.
  - One-shot: next edge goes to IDLE with out_valid=0, busy=0, done=1 for one cycle.
- STREAM with abort=1 (priority over a transfer in the same cycle):
  - Next edge: IDLE, out_valid=0, busy=0.
  - No done pulse; that cycle's transfer still counts as taken by the consumer.
- start while in STREAM: ignored.
- Latency: start to first out_valid is 1 cycle. Last transfer to done is 1 cycle.
- out_data and out_idx are registered. They keep their last value in IDLE.
- Asynchronous reset mid-playback:
  - Immediate return to the reset state; count=0.
  - Table must be reloaded before the next playback.

Test Plan:
- Load 9 entries, idx 0..8, data {y,x} = {0,0},{0,1},{2,1},{2,1},{0,4},{2,4},{6,5},{6,6},{8,7}; start with loop_mode=0 and out_ready=1.
  -> count=9; first out_valid 1 cycle after start; 9 consecutive transfers with idx 0..8 and matching data; done pulses once; busy falls with done.
- Same table, out_ready toggled 1,0,0,1,... -> out_data and out_idx stable through stalls; no entry skipped or duplicated; 9 transfers total.
- loop_mode=1, count=3, out_ready=1 for 7 transfers, then abort.
  -> idx sequence 0,1,2,0,1,2,0; out_valid=0 the cycle after abort; no done.
- wr_en with wr_idx=DEPTH in IDLE, and wr_en with wr_idx=0 during STREAM.
  -> wr_err pulses each time; memory and count unchanged.
- clear and then start with count=0 -> no out_valid; done pulses 1 cycle after start; busy stays 0.
- Assert rst while streaming idx 4.
  -> out_valid, busy and count read 0 immediately (asynchronous); after reload of 2 entries and start, playback is idx 0,1 only.

Source files
------------

// File: rtl/waypoint_table_if.sv
// Waypoint table bus: write port, control strobes and the playback stream.
//   master : the side that loads the table and consumes the stream
//   slave  : the waypoint_table itself
// Signals
//   wr_en/wr_idx/wr_data  table write port (dim 0 in the LSBs of wr_data)
//   wr_err                one-cycle pulse when a write is rejected
//   clear/start/abort     control strobes, loop_mode sampled at start
//   out_valid/out_ready   stream handshake, out_data/out_idx its payload
//   busy/done/count       playback status and live fill count
interface waypoint_table_if #(
   parameter int COORD_W = 8,
   parameter int NDIM    = 2,
   parameter int DEPTH   = 16,
   parameter int IDX_W   = $clog2(DEPTH)
);
   logic                    wr_en;
   logic [IDX_W-1:0]        wr_idx;
   logic [NDIM*COORD_W-1:0] wr_data;
   logic                    wr_err;
   logic                    clear;
   logic                    start;
   logic                    loop_mode;
   logic                    abort;
   logic                    out_valid;
   logic                    out_ready;
   logic [NDIM*COORD_W-1:0] out_data;
   logic [IDX_W-1:0]        out_idx;
   logic                    busy;
   logic                    done;
   logic [IDX_W:0]          count;

   modport master (
      output wr_en, wr_idx, wr_data, clear, start, loop_mode, abort, out_ready,
      input  wr_err, out_valid, out_data, out_idx, busy, done, count
   );

   modport slave (
      input  wr_en, wr_idx, wr_data, clear, start, loop_mode, abort, out_ready,
      output wr_err, out_valid, out_data, out_idx, busy, done, count
   );
endinterface

// File: rtl/waypoint_table.sv
// Writable table of DEPTH waypoints (NDIM coordinates of COORD_W bits each)
// replayed in index order over a valid/ready stream.
// Ports
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  waypoint_table_if.slave: write port, clear/start/abort/loop_mode,
//        out_valid/out_ready/out_data/out_idx stream, wr_err, busy, done, count
// The table is writable only while idle; count is a high-water mark of the
// written indices and the memory itself is never reset.
module waypoint_table #(
   parameter int COORD_W = 8,
   parameter int NDIM    = 2,
   parameter int DEPTH   = 16,
   parameter int IDX_W   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   waypoint_table_if.slave  bus
);
   localparam int DATA_W = NDIM * COORD_W;
   localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);
   localparam logic [IDX_W:0] ONE_C   = (IDX_W+1)'(1);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t             state_reg;
   logic [DATA_W-1:0]  mem [DEPTH];
   logic [IDX_W:0]     count_reg;
   logic               out_valid_reg;
   logic [DATA_W-1:0]  out_data_reg;
   logic [IDX_W-1:0]   out_idx_reg;
   logic               busy_reg;
   logic               done_reg;
   logic               wr_err_reg;
   logic               loop_reg;

   logic               idle;
   logic               wr_in_range;
   logic               wr_ok;
   logic               wr_reject;
   logic [IDX_W:0]     wr_top;
   logic               last_entry;
   logic [IDX_W-1:0]   next_idx;

   always_comb begin
      idle        = (state_reg == IDLE);
      wr_in_range = ({1'b0, bus.wr_idx} < DEPTH_C);
      // clear takes precedence over a same-cycle write, silently.
      wr_ok       = idle & bus.wr_en & ~bus.clear & wr_in_range;
      wr_reject   = bus.wr_en & (~idle | (~bus.clear & ~wr_in_range));
      wr_top      = {1'b0, bus.wr_idx} + ONE_C;
      last_entry  = ({1'b0, out_idx_reg} == (count_reg - ONE_C));
      next_idx    = out_idx_reg + IDX_W'(1);
   end

   // Table storage: no reset, written only while idle.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[bus.wr_idx] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         count_reg     <= '0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_idx_reg   <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         wr_err_reg    <= 1'b0;
         loop_reg      <= 1'b0;
      end else begin
         done_reg   <= 1'b0;
         wr_err_reg <= wr_reject;
         case (state_reg)
            IDLE: begin
               if (bus.clear) begin
                  count_reg <= '0;
               end else if (wr_ok && (wr_top > count_reg)) begin
                  count_reg <= wr_top;
               end
               if (bus.start) begin
                  if (count_reg != '0) begin
                     state_reg     <= STREAM;
                     out_valid_reg <= 1'b1;
                     busy_reg      <= 1'b1;
                     out_idx_reg   <= '0;
                     out_data_reg  <= mem[0];
                     loop_reg      <= bus.loop_mode;
                  end else begin
                     // Nothing to play: report completion immediately.
                     done_reg <= 1'b1;
                  end
               end
            end
            STREAM: begin
               // out_valid is always high here, so ready alone marks a transfer.
               if (bus.abort) begin
                  state_reg     <= IDLE;
                  out_valid_reg <= 1'b0;
                  busy_reg      <= 1'b0;
               end else if (bus.out_ready) begin
                  if (!last_entry) begin
                     out_idx_reg  <= next_idx;
                     out_data_reg <= mem[next_idx];
                  end else if (loop_reg) begin
                     out_idx_reg  <= '0;
                     out_data_reg <= mem[0];
                  end else begin
                     state_reg     <= IDLE;
                     out_valid_reg <= 1'b0;
                     busy_reg      <= 1'b0;
                     done_reg      <= 1'b1;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.out_valid = out_valid_reg;
   assign bus.out_data  = out_data_reg;
   assign bus.out_idx   = out_idx_reg;
   assign bus.busy      = busy_reg;
   assign bus.done      = done_reg;
   assign bus.wr_err    = wr_err_reg;
   assign bus.count     = count_reg;
endmodule

// File: tb/tb_waypoint_table.sv
// Testbench for waypoint_table: a reference table model produces the
// expected stream into a queue; a monitor on the falling edge pops and
// compares every transfer and checks payload stability during stalls.
module tb_waypoint_table;
   localparam int COORD_W = 8;
   localparam int NDIM    = 2;
   localparam int DEPTH   = 12;
   localparam int IDX_W   = $clog2(DEPTH);
   localparam int DW      = NDIM * COORD_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   waypoint_table_if #(.COORD_W(COORD_W), .NDIM(NDIM), .DEPTH(DEPTH)) bus();

   waypoint_table #(.COORD_W(COORD_W), .NDIM(NDIM), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [DW-1:0]    data;
   } xfer_t;

   xfer_t         exp_q[$];
   int            vectors     = 0;
   int            miscompares = 0;
   int            done_seen   = 0;
   int            xfers       = 0;
   logic [DW-1:0] model_mem [DEPTH];
   int            model_count = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor / scoreboard
   initial begin
      xfer_t            e;
      logic             stall_prev;
      logic [IDX_W-1:0] stall_idx;
      logic [DW-1:0]    stall_data;
      stall_prev = 1'b0;
      stall_idx  = '0;
      stall_data = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev && bus.out_valid) begin
               check("stall_idx_hold", 32'(bus.out_idx), 32'(stall_idx));
               check("stall_data_hold", 32'(bus.out_data), 32'(stall_data));
            end
            stall_prev = 1'b0;
            if (bus.out_valid) begin
               if (bus.out_ready) begin
                  xfers++;
                  if (exp_q.size() == 0) begin
                     vectors++;
                     miscompares++;
                     $display("FAIL unexpected_xfer: got idx %0d data %0h, expected none",
                              bus.out_idx, bus.out_data);
                  end else begin
                     e = exp_q.pop_front();
                     $display("xfer idx=%0d data=%04h (expect idx=%0d data=%04h)",
                              bus.out_idx, bus.out_data, e.idx, e.data);
                     check("xfer_idx", 32'(bus.out_idx), 32'(e.idx));
                     check("xfer_data", 32'(bus.out_data), 32'(e.data));
                  end
               end else begin
                  stall_prev = 1'b1;
                  stall_idx  = bus.out_idx;
                  stall_data = bus.out_data;
               end
            end
            if (bus.done) done_seen++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Idle-state write; the model applies the table rules directly.
   task automatic do_write(input int idx, input logic [DW-1:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_idx  = IDX_W'(idx);
      bus.wr_data = d;
      tick();
      bus.wr_en = 1'b0;
      if (idx < DEPTH) begin
         model_mem[idx] = d;
         if (idx + 1 > model_count) model_count = idx + 1;
      end
      check("wr_err", 32'(bus.wr_err), 32'(idx >= DEPTH));
   endtask

   task automatic do_clear();
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      model_count = 0;
   endtask

   task automatic push_playback();
      xfer_t t;
      for (int i = 0; i < model_count; i++) begin
         t.idx  = IDX_W'(i);
         t.data = model_mem[i];
         exp_q.push_back(t);
      end
   endtask

   task automatic start_play(input logic lm);
      bus.loop_mode = lm;
      bus.start     = 1'b1;
      tick();
      bus.start = 1'b0;
      check("first_valid", 32'(bus.out_valid), 32'(model_count > 0));
      check("busy_on", 32'(bus.busy), 32'(model_count > 0));
   endtask

   // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random
   task automatic drain(input int mode, input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
         case (mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = (n % 3 == 0);
            default: bus.out_ready = 1'($urandom_range(0, 1));
         endcase
         tick();
         n++;
      end
      if (n >= budget) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: got %0d entries pending, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic one_shot(input int mode);
      int d0;
      d0 = done_seen;
      push_playback();
      bus.out_ready = (mode != 1) ? 1'b1 : 1'b0;
      start_play(1'b0);
      drain(mode, 400);
      check("done_at_end", 32'(bus.done), 32'h1);
      check("busy_off", 32'(bus.busy), 32'h0);
      tick();
      check("done_count", 32'(done_seen - d0), 32'h1);
   endtask

   task automatic load_plan();
      int xs [9] = '{0, 1, 1, 1, 4, 4, 5, 6, 7};
      int ys [9] = '{0, 0, 2, 2, 0, 2, 6, 6, 8};
      for (int i = 0; i < 9; i++) do_write(i, {8'(ys[i]), 8'(xs[i])});
   endtask

   initial begin
      int d0;
      int base;
      int n;
      bus.wr_en = 0; bus.wr_idx = '0; bus.wr_data = '0; bus.clear = 0;
      bus.start = 0; bus.loop_mode = 0; bus.abort = 0; bus.out_ready = 0;

      // Reset state
      tick(); tick();
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_wr_err", 32'(bus.wr_err), 0);
      check("rst_count", 32'(bus.count), 0);
      check("rst_out_idx", 32'(bus.out_idx), 0);
      check("rst_out_data", 32'(bus.out_data), 0);
      rst = 1'b0;
      tick();

      // One-shot playback of the 9-entry table, always ready
      load_plan();
      check("count_9", 32'(bus.count), 9);
      do_write(2, model_mem[2]);
      check("overwrite_count", 32'(bus.count), 9);
      one_shot(0);

      // Same table with stalls
      one_shot(1);

      // Looping playback of 3 entries, 7 transfers, then abort
      do_clear();
      for (int i = 0; i < 3; i++) do_write(i, 16'($urandom));
      for (int i = 0; i < 7; i++) begin
         xfer_t t;
         t.idx  = IDX_W'(i % 3);
         t.data = model_mem[i % 3];
         exp_q.push_back(t);
      end
      d0 = done_seen;
      bus.out_ready = 1'b1;
      start_play(1'b1);
      base = xfers;
      n = 0;
      while (xfers < base + 7 && n < 50) begin tick(); n++; end
      check("loop_xfers", 32'(xfers - base), 7);
      bus.out_ready = 1'b0;
      bus.abort     = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("abort_valid", 32'(bus.out_valid), 0);
      check("abort_busy", 32'(bus.busy), 0);
      tick();
      check("abort_no_done", 32'(done_seen - d0), 0);
      check("loop_queue_empty", 32'(exp_q.size()), 0);
      exp_q.delete();

      // Rejected writes: out of range in idle, any write while streaming
      do_write(DEPTH, 16'hDEAD);
      tick();
      check("wr_err_pulse_end", 32'(bus.wr_err), 0);
      check("reject_count", 32'(bus.count), 3);
      push_playback();
      bus.out_ready = 1'b0;
      start_play(1'b0);
      bus.wr_en = 1'b1; bus.wr_idx = '0; bus.wr_data = 16'hFFFF;
      tick();
      bus.wr_en = 1'b0;
      check("wr_err_stream", 32'(bus.wr_err), 1);
      check("stream_write_count", 32'(bus.count), 3);
      drain(1, 100);
      tick();

      // clear with a same-cycle write, then start on an empty table
      bus.clear = 1'b1; bus.wr_en = 1'b1; bus.wr_idx = IDX_W'(5); bus.wr_data = 16'h1234;
      tick();
      bus.clear = 1'b0; bus.wr_en = 1'b0;
      model_count = 0;
      check("clear_no_wr_err", 32'(bus.wr_err), 0);
      check("clear_count", 32'(bus.count), 0);
      d0 = done_seen;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("empty_done", 32'(bus.done), 1);
      check("empty_valid", 32'(bus.out_valid), 0);
      check("empty_busy", 32'(bus.busy), 0);
      tick();
      check("empty_done_once", 32'(bus.done), 0);
      check("empty_done_count", 32'(done_seen - d0), 1);

      // Randomised loads and playback against the model
      for (int i = 0; i < DEPTH; i++) do_write(i, 16'($urandom));
      for (int r = 0; r < 4; r++) begin
         do_clear();
         n = $urandom_range(1, 10);
         for (int k = 0; k < n; k++) do_write($urandom_range(0, 15), 16'($urandom));
         check("rand_count", 32'(bus.count), 32'(model_count));
         if (model_count > 0) one_shot(2);
      end

      // Asynchronous reset while streaming idx 4
      do_clear();
      load_plan();
      push_playback();
      bus.out_ready = 1'b1;
      start_play(1'b0);
      n = 0;
      while (bus.out_idx != IDX_W'(4) && n < 20) begin tick(); n++; end
      check("reached_idx4", 32'(bus.out_idx), 4);
      #2 rst = 1'b1;
      #1;
      check("arst_valid", 32'(bus.out_valid), 0);
      check("arst_busy", 32'(bus.busy), 0);
      check("arst_count", 32'(bus.count), 0);
      exp_q.delete();
      model_count = 0;
      tick();
      rst = 1'b0;
      tick();
      do_write(0, 16'hA1B2);
      do_write(1, 16'hC3D4);
      one_shot(0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
